cory_arb4_rate: RTL
===================

# cory_arb4_rate

Four-input token-bucket rate arbiter: merges four valid/ready request streams onto one output, admitting a request only when its port holds enough credit. Credits refill per port at a programmed rate every programmed period, capped per port. Sits in front of shared memory/bus ports where each requester must be held to a guaranteed and bounded bandwidth, complementing the bandwidth-weighted arbiters in the same fabric.

## Interface
- N, 8, data bits per request
- C, 8, credit counter bits
- L, 4, cost field bits (beats-1, arlen style)
- P, 8, refill period counter bits
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- i_aK_v / i_aK_d / o_aK_r (K=0..3)  in/in/out  1/N/1  request handshake per port
- i_aK_len  in  L  request cost minus 1 (cost = len+1 credits)
- i_aK_rate  in  C  credits added per refill; 0 disables refill
- i_aK_cap  in  C  bucket ceiling
- i_period  in  P  refill every i_period+1 cycles
- o_z_v / o_z_d / i_z_r  out/out/in  1/N/1  merged output handshake
- o_z_s  out  2  granted port index

## Operation
- Eligible(K) = i_aK_v && credit[K] >= i_aK_len+1 (compare at C+1 bits).
- Grant: round-robin search of eligible ports starting at rr; rr resets 0, becomes granted+1 (mod 4) on each output handshake.
- o_z_v = any eligible (or held grant); o_z_d/o_z_s from selected port; o_aK_r = i_z_r && sel==K && o_z_v.
- Hold: if o_z_v && !i_z_r, latch sel into hold register; sel stays latched until handshake, even if a higher-RR port becomes eligible. Inputs must hold v/d/len while unaccepted; credit only rises while held, so eligibility persists.
- Timer: counts 0..i_period; refill pulse when timer >= i_period, then timer <= 0. Lowering i_period below current count fires refill next cycle.
- Credit update per port, C+1-bit arithmetic: base = credit - cost on its handshake else credit; on refill base += rate; result = min(base, cap). Handshake and refill in same cycle apply both.
- cap < cost: port never eligible in strict mode (SIM warning). rate==0: port never refills.
- Reset mid-operation: credits, timer, rr, hold cleared; in-flight request dropped.

## Timing
- Reset values: o_z_v 0, o_z_s 0, o_z_d 0 (mux of port 0 gated), all o_aK_r 0, credits 0, timer 0.
- Request to output: 0 cycles (combinational mux); ready path combinational from i_z_r.
- Credit change visible one cycle after handshake/refill edge.
- First refill P0 = i_period+1 cycles after reset release; strict mode: no grant before it.
- Steady-state port throughput bound: rate/(period+1) credits per cycle.

## Configuration
- CORY_ARB4_RATE_WORK_CONSERVE_EN defined: when no port is eligible, any valid port is granted round-robin; its debit saturates credit at 0 (no debt carried). Undefined: strict shaping, output idle when no port has credit.

## Structure
- Shared include: credit/cost width constants, port-index encoding, cost function (len+1).
- Sub-module _cory_arb4_rate_bucket: one per port; holds credit, computes eligible and next credit from handshake, refill, rate, cap, cost. Top holds timer, RR pointer, hold register, mux.

## Test plan
- Reset, period=3, rate0=4, cap0=8, len0=3, a0_v held, z_r=1 -> o_z_v 0 for cycles 0-3, one grant after first refill, then one grant every 4 cycles.
- All four valid, rate=cap=16, len=0, period=0 -> grants rotate 0,1,2,3,0 each cycle; o_z_s matches.
- Port 1 granted with z_r=0 for 5 cycles while port 0 gains credit -> o_z_s stays 1, d stable, credit1 unchanged until accept.
- cap0=4, rate0=8, no traffic 10 periods -> credit0 saturates at 4; len0=4 (cost 5) -> never granted in strict mode.
- Handshake on refill cycle: credit 5, cost 2, rate 3, cap 10 -> credit 6 next cycle.
- WORK_CONSERVE_EN, all credits 0, a2_v=1 -> granted immediately, credit2 stays 0; without macro -> no grant until refill.

Source files
------------

// File: rtl/cory_arb4_rate_pkg.sv
// cory_arb4_rate_pkg
// Shared constants and helpers for the cory_arb4_rate token-bucket arbiter:
// default data/credit/cost/period widths, port-index encoding, arbitration
// state encoding, and the request cost function (len + 1 credits).
package cory_arb4_rate_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned CREDIT_W  = 8;
  localparam int unsigned LEN_W     = 4;
  localparam int unsigned PERIOD_W  = 8;
  localparam int unsigned NUM_PORTS = 4;

  typedef logic [1:0] port_idx_t;

  // ARB_OPEN: selection follows the round-robin search every cycle.
  // ARB_HOLD: an offered grant was not accepted; selection is frozen.
  typedef enum logic {
    ARB_OPEN,
    ARB_HOLD
  } arb_state_t;

  // A request of len (arlen style, beats-1) costs len+1 credits.
  function automatic int unsigned cost_of(input int unsigned len);
    return len + 1;
  endfunction

endpackage

// File: rtl/cory_arb4_rate_bucket.sv
// cory_arb4_rate_bucket
// One token bucket. Holds the port's credit, reports eligibility and updates
// credit from the port's handshake (debit) and the shared refill pulse.
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   i_v, i_len       request valid and cost field (cost = len+1)
//   i_rate, i_cap    credits added per refill, bucket ceiling
//   i_refill         shared refill pulse from the period timer
//   i_take           this port's request is accepted this cycle
//   o_elig           valid and credit covers the cost
module cory_arb4_rate_bucket
  import cory_arb4_rate_pkg::*;
#(
  parameter int unsigned C = CREDIT_W,
  parameter int unsigned L = LEN_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_v,
  input  logic [L-1:0] i_len,
  input  logic [C-1:0] i_rate,
  input  logic [C-1:0] i_cap,
  input  logic         i_refill,
  input  logic         i_take,
  output logic         o_elig
);

  logic [C-1:0] credit;
  logic [C-1:0] credit_nxt;
  logic [C:0]   cost;
  logic [C:0]   base;

  always_comb begin
    cost   = (C+1)'(cost_of(32'(i_len)));
    o_elig = i_v && ({1'b0, credit} >= cost);

    // Debit saturates at zero so a work-conserving grant without credit
    // never leaves debt behind; a strict grant always has credit >= cost.
    base = {1'b0, credit};
    if (i_take) begin
      base = (base >= cost) ? (base - cost) : '0;
    end
    if (i_refill) begin
      base = base + {1'b0, i_rate};
    end
    credit_nxt = (base > {1'b0, i_cap}) ? i_cap : base[C-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credit <= '0;
    end else begin
      credit <= credit_nxt;
    end
  end

endmodule

// File: rtl/cory_arb4_rate.sv
// cory_arb4_rate
// Four-input token-bucket rate arbiter. Merges four valid/ready request
// streams onto one output; a port is admitted only while its bucket holds
// enough credit. Buckets refill by i_aK_rate every i_period+1 cycles, capped
// at i_aK_cap. Round-robin among eligible ports; an unaccepted grant is held.
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   i_aK_v / i_aK_d / o_aK_r       per-port request handshake (K=0..3)
//   i_aK_len                       request cost minus 1
//   i_aK_rate, i_aK_cap            refill amount (0 = no refill), ceiling
//   i_period                       refill every i_period+1 cycles
//   o_z_v / o_z_d / i_z_r          merged output handshake
//   o_z_s                          granted port index
// Build option: CORY_ARB4_RATE_WORK_CONSERVE_EN -- when no port has credit,
// grant any valid port round-robin (debit saturates at 0). Default: strict.
module cory_arb4_rate
  import cory_arb4_rate_pkg::*;
#(
  parameter int unsigned N = DATA_W,
  parameter int unsigned C = CREDIT_W,
  parameter int unsigned L = LEN_W,
  parameter int unsigned P = PERIOD_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_a0_v,
  input  logic [N-1:0] i_a0_d,
  output logic         o_a0_r,
  input  logic [L-1:0] i_a0_len,
  input  logic [C-1:0] i_a0_rate,
  input  logic [C-1:0] i_a0_cap,
  input  logic         i_a1_v,
  input  logic [N-1:0] i_a1_d,
  output logic         o_a1_r,
  input  logic [L-1:0] i_a1_len,
  input  logic [C-1:0] i_a1_rate,
  input  logic [C-1:0] i_a1_cap,
  input  logic         i_a2_v,
  input  logic [N-1:0] i_a2_d,
  output logic         o_a2_r,
  input  logic [L-1:0] i_a2_len,
  input  logic [C-1:0] i_a2_rate,
  input  logic [C-1:0] i_a2_cap,
  input  logic         i_a3_v,
  input  logic [N-1:0] i_a3_d,
  output logic         o_a3_r,
  input  logic [L-1:0] i_a3_len,
  input  logic [C-1:0] i_a3_rate,
  input  logic [C-1:0] i_a3_cap,
  input  logic [P-1:0] i_period,
  output logic         o_z_v,
  output logic [N-1:0] o_z_d,
  input  logic         i_z_r,
  output logic [1:0]   o_z_s
);

  logic [3:0]   v;
  logic [N-1:0] d [4];
  logic [3:0]   elig;
  logic [3:0]   cand;
  logic [3:0]   take;
  logic [P-1:0] timer;
  logic         refill;
  port_idx_t    rr;
  port_idx_t    pick;
  port_idx_t    sel;
  port_idx_t    hold_sel;
  port_idx_t    idx;
  logic         found;
  logic         hs;
  arb_state_t   state;
  arb_state_t   state_nxt;

  assign v    = {i_a3_v, i_a2_v, i_a1_v, i_a0_v};
  assign d[0] = i_a0_d;
  assign d[1] = i_a1_d;
  assign d[2] = i_a2_d;
  assign d[3] = i_a3_d;

  // Refill timer; >= so lowering i_period below the count fires next cycle.
  assign refill = (timer >= i_period);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer <= '0;
    end else if (refill) begin
      timer <= '0;
    end else begin
      timer <= timer + P'(1);
    end
  end

  cory_arb4_rate_bucket #(.C(C), .L(L)) u_bkt0 (
    .clk(clk), .reset_n(reset_n), .i_v(i_a0_v), .i_len(i_a0_len),
    .i_rate(i_a0_rate), .i_cap(i_a0_cap), .i_refill(refill),
    .i_take(take[0]), .o_elig(elig[0])
  );
  cory_arb4_rate_bucket #(.C(C), .L(L)) u_bkt1 (
    .clk(clk), .reset_n(reset_n), .i_v(i_a1_v), .i_len(i_a1_len),
    .i_rate(i_a1_rate), .i_cap(i_a1_cap), .i_refill(refill),
    .i_take(take[1]), .o_elig(elig[1])
  );
  cory_arb4_rate_bucket #(.C(C), .L(L)) u_bkt2 (
    .clk(clk), .reset_n(reset_n), .i_v(i_a2_v), .i_len(i_a2_len),
    .i_rate(i_a2_rate), .i_cap(i_a2_cap), .i_refill(refill),
    .i_take(take[2]), .o_elig(elig[2])
  );
  cory_arb4_rate_bucket #(.C(C), .L(L)) u_bkt3 (
    .clk(clk), .reset_n(reset_n), .i_v(i_a3_v), .i_len(i_a3_len),
    .i_rate(i_a3_rate), .i_cap(i_a3_cap), .i_refill(refill),
    .i_take(take[3]), .o_elig(elig[3])
  );

  // Candidate set and round-robin search starting at rr.
  always_comb begin
`ifdef CORY_ARB4_RATE_WORK_CONSERVE_EN
    cand = (|elig) ? elig : v;
`else
    cand = elig;
`endif
    pick  = rr;
    found = 1'b0;
    idx   = rr;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      idx = rr + port_idx_t'(i);
      if (!found && cand[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // Selection, handshake and hold FSM next state.
  always_comb begin
    sel       = (state == ARB_HOLD) ? hold_sel : pick;
    o_z_v     = (state == ARB_HOLD) || (|cand);
    hs        = o_z_v && i_z_r;
    state_nxt = state;
    case (state)
      ARB_OPEN: if (o_z_v && !i_z_r) state_nxt = ARB_HOLD;
      ARB_HOLD: if (i_z_r)           state_nxt = ARB_OPEN;
      default:                       state_nxt = ARB_OPEN;
    endcase
    take = '0;
    if (hs) begin
      take[sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ARB_OPEN;
      hold_sel <= '0;
      rr       <= '0;
    end else begin
      state <= state_nxt;
      if (o_z_v && !i_z_r) begin
        hold_sel <= sel;
      end
      if (hs) begin
        rr <= sel + port_idx_t'(1);
      end
    end
  end

  assign o_z_s  = sel;
  assign o_z_d  = o_z_v ? d[sel] : '0;
  assign o_a0_r = take[0];
  assign o_a1_r = take[1];
  assign o_a2_r = take[2];
  assign o_a3_r = take[3];

endmodule
